spi_regbus: RTL

SPI_REGBUS -- requirements
Module: spi_regbus

---
 rtl/spi_regbus.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/spi_regbus.sv
// SPI-to-register-bus bridge. The first byte of a frame is a command:
// bit 7 selects read (1) or write (0), bits 6:0 give the start address.
// Write frames are followed by data bytes. Each data byte becomes one bus
// write, and the address auto-increments after each one. Read frames issue
// a bus read at once. The result is loaded into tx_byte for the next byte
// slot, and each later received byte triggers the next read.
//
// Bus handshake: bus_we/bus_re is a level request, held from the cycle it
// rises until the cycle in which bus_ack is sampled high (inclusive), or
// until TIMEOUT request-high cycles pass without an ack. bus_ack is a
// single-cycle pulse. It counts only while a request is high, and an ack
// in the expiry cycle wins over the timeout. bus_rdata is sampled with
// bus_ack.
//
// dbg_state exposes the FSM state for checkers:
// 0 IDLE, 1 CMD, 2 WRITE, 3 WR_BUS, 4 RD_BUS, 5 RD_WAIT.
module spi_regbus #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       frame_active,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic [7:0] tx_byte,
  output logic [6:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_we,
  output logic       bus_re,
  input  logic [7:0] bus_rdata,
  input  logic       bus_ack,
  output logic       err,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    WRITE   = 3'd2,
    WR_BUS  = 3'd3,
    RD_BUS  = 3'd4,
    RD_WAIT = 3'd5
  } state_t;

  // Counter value seen in the last allowed request-high cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [7:0] tx_n, wdata_n;
  logic [6:0] addr_n;
  logic       we_n, re_n, err_n;
  logic       expire;

  assign expire    = (cnt == CNT_LAST);
  assign dbg_state = state;

  // Next state and next registered outputs.
  // Priority: frame_start, then frame end, then per-state events.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tx_n    = tx_byte;
    addr_n  = bus_addr;
    wdata_n = bus_wdata;
    we_n    = bus_we;
    re_n    = bus_re;
    err_n   = err;
    if (frame_start) begin
      state_n = CMD;
      err_n   = 1'b0;
      tx_n    = 8'h00;
      we_n    = 1'b0;
      re_n    = 1'b0;
      cnt_n   = 8'd0;
    end else if (!frame_active && state != IDLE) begin
      state_n = IDLE;
      we_n    = 1'b0;
      re_n    = 1'b0;
      cnt_n   = 8'd0;
    end else begin
      case (state)
        CMD: begin
          if (rx_valid) begin
            addr_n = rx_byte[6:0];
            cnt_n  = 8'd0;
            if (rx_byte[7]) begin
              state_n = RD_BUS;
              re_n    = 1'b1;
            end else begin
              state_n = WRITE;
            end
          end
        end
        WRITE: begin
          if (rx_valid) begin
            wdata_n = rx_byte;
            we_n    = 1'b1;
            cnt_n   = 8'd0;
            state_n = WR_BUS;
          end
        end
        WR_BUS: begin
          // A byte arriving while the bus is busy is an overrun.
          if (rx_valid) err_n = 1'b1;
          if (bus_we && bus_ack) begin
            we_n    = 1'b0;
            addr_n  = bus_addr + 7'd1;
            state_n = WRITE;
          end else if (expire) begin
            we_n    = 1'b0;
            err_n   = 1'b1;
            addr_n  = bus_addr + 7'd1;
            state_n = WRITE;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        RD_BUS: begin
          if (rx_valid) err_n = 1'b1;
          if (bus_re && bus_ack) begin
            re_n    = 1'b0;
            tx_n    = bus_rdata;
            addr_n  = bus_addr + 7'd1;
            state_n = RD_WAIT;
          end else if (expire) begin
            re_n    = 1'b0;
            tx_n    = 8'hFF;
            err_n   = 1'b1;
            addr_n  = bus_addr + 7'd1;
            state_n = RD_WAIT;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        RD_WAIT: begin
          // The received byte is a dummy; it only paces the next read.
          if (rx_valid) begin
            re_n    = 1'b1;
            cnt_n   = 8'd0;
            state_n = RD_BUS;
          end
        end
        IDLE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      tx_byte   <= 8'h00;
      bus_addr  <= 7'd0;
      bus_wdata <= 8'h00;
      bus_we    <= 1'b0;
      bus_re    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      tx_byte   <= tx_n;
      bus_addr  <= addr_n;
      bus_wdata <= wdata_n;
      bus_we    <= we_n;
      bus_re    <= re_n;
      err       <= err_n;
    end
  end

endmodule
